// File: rtl/psum_acc_sequencer.sv
// Partial-sum accumulation sequencer: streams groups of psum rows from psum SRAM into the
// SFU with the acc pulse train and writes each ReLU'd SFU result back to output SRAM.
module psum_acc_sequencer #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [addr_bw-1:0]       psum_base_i,
  input  logic [addr_bw-1:0]       out_base_i,
  input  logic [cnt_bw-1:0]        num_psum_i,
  input  logic [cnt_bw-1:0]        num_out_i,
  output logic                     pmem_cen_o,
  output logic [addr_bw-1:0]       pmem_addr_o,
  input  logic [col*psum_bw-1:0]   pmem_rdata_i,
  output logic                     acc_o,
  output logic [col*psum_bw-1:0]   psum_o,
  input  logic [col*psum_bw-1:0]   sfu_psum_i,
  output logic                     omem_cen_o,
  output logic                     omem_wen_o,
  output logic [addr_bw-1:0]       omem_addr_o,
  output logic [col*psum_bw-1:0]   omem_wdata_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [addr_bw-1:0] ADDR_ONE = addr_bw'(1);
  localparam logic [cnt_bw-1:0]  CNT_ONE  = cnt_bw'(1);

  logic [1:0]        state;
  logic [cnt_bw-1:0] num_psum_q;
  logic [cnt_bw-1:0] num_out_q;
  logic [cnt_bw-1:0] rd_idx;
  logic [cnt_bw-1:0] grp_idx;
  logic [cnt_bw-1:0] wr_cnt;
  logic              acc_d1;
  logic              wr_fire;

  // A write is due one cycle after acc falls: acc high two cycles back, low last cycle.
  assign wr_fire = acc_d1 & ~acc_o;

  // NOTE: every register below uses non-blocking assignment so all state updates see the
  // pre-edge values; blocking here would make acc_o/acc_d1 collapse into one stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_o      <= 1'b0;
      acc_d1     <= 1'b0;
      omem_cen_o <= 1'b1;
    end else begin
      acc_o      <= ~pmem_cen_o;
      acc_d1     <= acc_o;
      omem_cen_o <= ~wr_fire;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      omem_addr_o <= '0;
      wr_cnt      <= '0;
    end else if (state == S_IDLE && start_i) begin
      omem_addr_o <= out_base_i;
      wr_cnt      <= '0;
    end else if (!omem_cen_o) begin
      omem_addr_o <= omem_addr_o + ADDR_ONE;
      wr_cnt      <= wr_cnt + CNT_ONE;
    end
  end

  // Read address just increments across reads and bubbles, which yields base + g*N + k
  // without any multiplier; it wraps naturally at 2^addr_bw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      num_psum_q  <= '0;
      num_out_q   <= '0;
      rd_idx      <= '0;
      grp_idx     <= '0;
      pmem_cen_o  <= 1'b1;
      pmem_addr_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            num_psum_q  <= num_psum_i;
            num_out_q   <= num_out_i;
            rd_idx      <= '0;
            grp_idx     <= '0;
            pmem_addr_o <= psum_base_i;
            if (num_psum_i == '0 || num_out_i == '0) begin
              state <= S_DONE;
            end else begin
              state      <= S_RUN;
              pmem_cen_o <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (!pmem_cen_o) begin
            pmem_addr_o <= pmem_addr_o + ADDR_ONE;
            if (rd_idx == num_psum_q - CNT_ONE) begin
              pmem_cen_o <= 1'b1;
            end else begin
              rd_idx <= rd_idx + CNT_ONE;
            end
          end else if (grp_idx == num_out_q - CNT_ONE) begin
            state <= S_DRAIN;
          end else begin
            grp_idx    <= grp_idx + CNT_ONE;
            rd_idx     <= '0;
            pmem_cen_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!omem_cen_o && wr_cnt == num_out_q - CNT_ONE) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign psum_o       = acc_o ? pmem_rdata_i : '0;
  assign omem_wen_o   = omem_cen_o;
  assign omem_wdata_o = sfu_psum_i;
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Scoreboard bench for psum_acc_sequencer: stimulus pushes expected reads, writes and done
// cycles; a negedge monitor pops and compares whenever the DUT presents them.
module tb_psum_acc_sequencer;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;
  localparam int CBW = 8;
  localparam int DW  = COL * PBW;

  typedef struct {
    logic [ABW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start_i;
  logic [ABW-1:0] psum_base_i;
  logic [ABW-1:0] out_base_i;
  logic [CBW-1:0] num_psum_i;
  logic [CBW-1:0] num_out_i;
  logic           pmem_cen_o;
  logic [ABW-1:0] pmem_addr_o;
  logic [DW-1:0]  pmem_rdata_i;
  logic           acc_o;
  logic [DW-1:0]  psum_o;
  logic [DW-1:0]  sfu_psum_i;
  logic           omem_cen_o;
  logic           omem_wen_o;
  logic [ABW-1:0] omem_addr_o;
  logic [DW-1:0]  omem_wdata_o;
  logic           busy_o;
  logic           done_o;

  psum_acc_sequencer #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .cnt_bw(CBW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .psum_base_i(psum_base_i), .out_base_i(out_base_i),
    .num_psum_i(num_psum_i), .num_out_i(num_out_i),
    .pmem_cen_o(pmem_cen_o), .pmem_addr_o(pmem_addr_o), .pmem_rdata_i(pmem_rdata_i),
    .acc_o(acc_o), .psum_o(psum_o), .sfu_psum_i(sfu_psum_i),
    .omem_cen_o(omem_cen_o), .omem_wen_o(omem_wen_o), .omem_addr_o(omem_addr_o),
    .omem_wdata_o(omem_wdata_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ecnt = 0;
  int t0 = 0;

  logic [ABW-1:0] rd_q[$];
  wr_t            wr_q[$];
  int             done_q[$];

  logic [DW-1:0] pmem [0:(1<<ABW)-1];
  logic [DW-1:0] sfu_sum;
  logic          sfu_acc_q;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT event at cycle %0d with nothing expected", name, ecnt - t0 + 1);
  endtask

  function automatic logic [DW-1:0] fill(input logic [PBW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic [DW-1:0] add_rows(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = a[l*PBW +: PBW] + b[l*PBW +: PBW];
    return r;
  endfunction

  function automatic logic [DW-1:0] relu_row(input logic [DW-1:0] a);
    logic [DW-1:0] r;
    for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = a[l*PBW+PBW-1] ? '0 : a[l*PBW +: PBW];
    return r;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  // Psum SRAM: data valid the cycle after chip enable.
  always @(posedge clk) if (!pmem_cen_o) pmem_rdata_i <= pmem[pmem_addr_o];

  // SFU: restarts accumulation on the first acc after a low cycle; ReLU output one cycle later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sfu_sum    <= '0;
      sfu_acc_q  <= 1'b0;
      sfu_psum_i <= '0;
    end else begin
      sfu_acc_q  <= acc_o;
      if (acc_o) sfu_sum <= add_rows(sfu_acc_q ? sfu_sum : '0, psum_o);
      sfu_psum_i <= relu_row(sfu_sum);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!pmem_cen_o) begin
        if (rd_q.size() == 0) unexpected("rd_unexpected");
        else check("rd_addr", pmem_addr_o, rd_q.pop_front());
      end
      if (!omem_cen_o || !omem_wen_o) begin
        check("wr_wen_eq_cen", omem_wen_o, omem_cen_o);
        if (wr_q.size() == 0) unexpected("wr_unexpected");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", omem_addr_o, e.addr);
          check("wr_data", omem_wdata_o, e.data);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) unexpected("done_unexpected");
        else check("done_cycle", ecnt - t0 + 1, done_q.pop_front());
      end
    end
  end

  task automatic start_run(input logic [ABW-1:0] pb, input logic [ABW-1:0] ob,
                           input logic [CBW-1:0] n, input logic [CBW-1:0] m);
    @(negedge clk);
    psum_base_i = pb;
    out_base_i  = ob;
    num_psum_i  = n;
    num_out_i   = m;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t0 = ecnt;
  endtask

  task automatic push_reads(input logic [ABW-1:0] base, input int cnt);
    logic [ABW-1:0] a;
    a = base;
    for (int i = 0; i < cnt; i++) begin
      rd_q.push_back(a);
      a = a + 1'b1;
    end
  endtask

  task automatic push_wr(input logic [ABW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((done_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({name, "_done_left"}, done_q.size(), 0);
    check({name, "_wr_left"}, wr_q.size(), 0);
    check({name, "_rd_left"}, rd_q.size(), 0);
    done_q.delete();
    wr_q.delete();
    rd_q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_pmem_cen"}, pmem_cen_o, 1'b1);
    check({name, "_omem_cen"}, omem_cen_o, 1'b1);
    check({name, "_omem_wen"}, omem_wen_o, 1'b1);
    check({name, "_acc"}, acc_o, 1'b0);
    check({name, "_psum"}, psum_o, '0);
    check({name, "_paddr"}, pmem_addr_o, '0);
    check({name, "_oaddr"}, omem_addr_o, '0);
    check({name, "_busy"}, busy_o, 1'b0);
    check({name, "_done"}, done_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] row;
    reset = 1'b1;
    start_i = 1'b0;
    psum_base_i = '0;
    out_base_i = '0;
    num_psum_i = '0;
    num_out_i = '0;
    for (int i = 0; i < (1 << ABW); i++) pmem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Reset mid-RUN aborts; then a full N=4, M=3 run.
    for (int i = 0; i < 12; i++) pmem[11'h400 + i] = fill(16'(i + 1));
    push_reads(11'h400, 4);
    start_run(11'h400, 11'h600, 8'd4, 8'd3);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    check("abort_reads_seen", rd_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    push_reads(11'h400, 12);
    push_wr(11'h600, fill(16'd10));
    push_wr(11'h601, fill(16'd26));
    push_wr(11'h602, fill(16'd42));
    done_q.push_back(18);
    start_run(11'h400, 11'h600, 8'd4, 8'd3);
    wait_drain("t1", 40);

    // N=3, M=2 basic accumulation.
    for (int i = 0; i < 6; i++) pmem[11'h010 + i] = fill(16'(i + 1));
    push_reads(11'h010, 6);
    push_wr(11'h200, fill(16'd6));
    push_wr(11'h201, fill(16'd15));
    done_q.push_back(11);
    start_run(11'h010, 11'h200, 8'd3, 8'd2);
    wait_drain("t2", 40);

    // ReLU: lane0 -5+2 -> 0, lane1 3+4 -> 7, lane2 0x100+0x23 -> 0x123.
    row = '0;
    row[15:0] = 16'hFFFB; row[31:16] = 16'd3; row[47:32] = 16'h0100;
    pmem[11'h100] = row;
    row = '0;
    row[15:0] = 16'd2; row[31:16] = 16'd4; row[47:32] = 16'h0023;
    pmem[11'h101] = row;
    row = '0;
    row[31:16] = 16'd7; row[47:32] = 16'h0123;
    push_reads(11'h100, 2);
    push_wr(11'h300, row);
    done_q.push_back(6);
    start_run(11'h100, 11'h300, 8'd2, 8'd1);
    wait_drain("t3", 40);

    // N=1, M=4: acc alternates, psum_o gated by acc.
    for (int i = 0; i < 4; i++) pmem[11'h030 + i] = fill(16'(10 * (i + 1)));
    push_reads(11'h030, 4);
    for (int i = 0; i < 4; i++) push_wr(11'(11'h050 + i), fill(16'(10 * (i + 1))));
    done_q.push_back(11);
    start_run(11'h030, 11'h050, 8'd1, 8'd4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("t4_acc_c%0d", c), acc_o, (c % 2 == 0 && c <= 8) ? 1'b1 : 1'b0);
      if (c == 2) check("t4_psum_c2", psum_o, fill(16'd10));
      if (c == 3) check("t4_psum_c3", psum_o, '0);
    end
    wait_drain("t4", 40);

    // Read address wrap, start during RUN ignored.
    pmem[11'h7FE] = fill(16'd1);
    pmem[11'h7FF] = fill(16'd2);
    pmem[11'h000] = fill(16'd3);
    pmem[11'h001] = fill(16'd4);
    rd_q.push_back(11'h7FE);
    rd_q.push_back(11'h7FF);
    rd_q.push_back(11'h000);
    rd_q.push_back(11'h001);
    push_wr(11'h7FF, fill(16'd10));
    done_q.push_back(8);
    start_run(11'h7FE, 11'h7FF, 8'd4, 8'd1);
    @(negedge clk);
    @(negedge clk);
    check("t5_busy", busy_o, 1'b1);
    psum_base_i = 11'h040;
    out_base_i  = 11'h070;
    num_psum_i  = 8'd7;
    num_out_i   = 8'd9;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_drain("t5", 40);

    // Zero N or zero M: immediate done, no memory access.
    done_q.push_back(1);
    start_run(11'h010, 11'h200, 8'd0, 8'd5);
    @(negedge clk);
    check("t6a_done", done_o, 1'b1);
    check("t6a_busy", busy_o, 1'b1);
    @(negedge clk);
    check("t6a_busy_after", busy_o, 1'b0);
    wait_drain("t6a", 10);
    done_q.push_back(1);
    start_run(11'h010, 11'h200, 8'd3, 8'd0);
    @(negedge clk);
    check("t6b_done", done_o, 1'b1);
    wait_drain("t6b", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
